// File: rtl/rv_pkg.sv
// Shared types and constants for the data-memory arbiter.
package rv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/rv_dmem_arbiter_rr.sv
// Combinational two-way round-robin picker: under contention the port that
// did not win last time is granted; a lone requester always wins.
module rv_rr_arb2
    import rv_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = PORT_CORE;
        if (req[PORT_CORE] && req[PORT_DBG]) begin
            gnt_id = ~last;
        end else if (req[PORT_DBG]) begin
            gnt_id = PORT_DBG;
        end
        gnt[gnt_id] = |req;
    end

endmodule

// File: rtl/rv_dmem_arbiter.sv
// Shares one data memory between the core load/store port and the debug port.
// One request in flight; the response cycle overlaps acceptance of the next.
module rv_dmem_arbiter
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              req_we_i,
    input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
    output logic [1:0]              rsp_valid_o,
    output logic                    rsp_err_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    core_stall_o
);

    dmem_arb_state_t state, state_nxt;

    logic                  last_grant;
    logic                  own_id;
    logic                  own_we;
    logic                  own_mis;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_wdata;

    logic [1:0]            arb_req;
    logic [1:0]            gnt;
    logic                  gnt_id;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // No new request may be taken while the memory access is being issued.
    assign arb_req = (state == ACCESS) ? 2'b00 : req_valid_i;

    rv_rr_arb2 u_rr (
        .req    (arb_req),
        .last   (last_grant),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign accept       = |gnt;
    assign req_ready_o  = gnt;
    assign core_stall_o = req_valid_i[PORT_CORE] & ~gnt[PORT_CORE];

    assign sel_addr  = gnt_id ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : req_addr_i[ADDR_WIDTH-1:0];
    assign sel_wdata = gnt_id ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                              : req_wdata_i[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= PORT_DBG;
            own_id     <= PORT_CORE;
            own_we     <= 1'b0;
            own_mis    <= 1'b0;
            own_addr   <= '0;
            own_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= gnt_id;
                own_id     <= gnt_id;
                own_we     <= gnt_id ? req_we_i[PORT_DBG] : req_we_i[PORT_CORE];
                own_mis    <= (sel_addr[1:0] != 2'b00);
                own_addr   <= sel_addr;
                own_wdata  <= sel_wdata;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rsp_valid_o = 2'b00;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = '0;
        case (state)
            IDLE: begin
                state_nxt = accept ? ACCESS : IDLE;
            end
            ACCESS: begin
                mem_en_o    = ~own_mis;
                mem_we_o    = own_we & ~own_mis;
                mem_addr_o  = own_addr;
                mem_wdata_o = own_wdata;
                state_nxt   = RESP;
            end
            RESP: begin
                rsp_valid_o = own_id ? 2'b10 : 2'b01;
                rsp_err_o   = own_mis;
                if (!own_we && !own_mis) begin
                    rsp_rdata_o = mem_rdata_i;
                end
                state_nxt = accept ? ACCESS : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// Bench for rv_dmem_arbiter: directed vector table, corner-case sequences and
// randomized traffic, all checked every cycle by a rule-level reference model.
module tb_rv_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_we = 2'b00;
    logic [AW-1:0]   t_addr [2];
    logic [DW-1:0]   t_wdata [2];
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ready, rsp_valid;
    logic            rsp_err, mem_en, mem_we, core_stall;
    logic [DW-1:0]   rsp_rdata, mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic [AW-1:0]   mem_addr;

    assign req_addr  = {t_addr[1], t_addr[0]};
    assign req_wdata = {t_wdata[1], t_wdata[0]};

    rv_dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_err_o    (rsp_err),
        .rsp_rdata_o  (rsp_rdata),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .core_stall_o (core_stall)
    );

    function automatic logic [DW-1:0] init_val(int i);
        return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + i * 32'h0101);
    endfunction

    // Synchronous memory with one-cycle read latency.
    logic          preload = 1'b1;
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    // Reference model: an accepted request blocks acceptance for one cycle,
    // touches memory one cycle after acceptance and is answered two cycles after.
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            acc_cyc = -10;
    int            acc_port = -1;
    int            rsp_cnt = 0;
    logic          m_last = 1'b1;
    logic          p_port = 1'b0;
    logic          p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;
    logic [DW-1:0] ref_mem [256];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        logic [1:0] exp_ready;
        logic       win, acc, mis;
        exp_ready = 2'b00;
        win = 1'b0;
        acc = 1'b0;
        if (cyc != acc_cyc + 1) begin
            if (req_valid == 2'b11)  begin win = ~m_last; acc = 1'b1; end
            else if (req_valid[0])   begin win = 1'b0;    acc = 1'b1; end
            else if (req_valid[1])   begin win = 1'b1;    acc = 1'b1; end
        end
        if (acc) exp_ready[win] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        chk("core_stall", core_stall, req_valid[0] & ~exp_ready[0]);

        mis = (p_addr[1:0] != 2'b00);
        if (cyc == acc_cyc + 1) begin
            chk("mem_en", mem_en, !mis);
            if (!mis) begin
                chk("mem_we", mem_we, p_we);
                chk("mem_addr", mem_addr, p_addr);
                if (p_we) chk("mem_wdata", mem_wdata, p_wdata);
            end
        end else begin
            chk("mem_en_quiet", mem_en, 0);
        end

        if (cyc == acc_cyc + 2) begin
            chk("rsp_valid", rsp_valid, p_port ? 2'b10 : 2'b01);
            chk("rsp_err", rsp_err, mis);
            chk("rsp_rdata", rsp_rdata, (p_we || mis) ? '0 : ref_mem[p_addr[9:2]]);
            rsp_cnt++;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end else begin
            chk("rsp_valid_quiet", rsp_valid, 0);
        end

        acc_port = -1;
        if (acc) begin
            m_last   = win;
            acc_cyc  = cyc;
            p_port   = win;
            p_we     = req_we[win];
            p_addr   = t_addr[win];
            p_wdata  = t_wdata[win];
            acc_port = int'(win);
            if (p_we && p_addr[1:0] == 2'b00) ref_mem[p_addr[9:2]] = p_wdata;
        end
        cyc++;
    endtask

    // Called at a falling edge with inputs already set.
    task automatic cycle();
        #1;
        model_check();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_core_stall", core_stall, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        acc_cyc = -10;
        m_last  = 1'b1;
        cyc     = 0;
    endtask

    task automatic set_req(int p, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        req_we[p]    = we;
        t_addr[p]    = a;
        t_wdata[p]   = d;
        req_valid[p] = 1'b1;
    endtask

    task automatic wait_accept(int p, string name);
        int w;
        w = 0;
        do begin
            cycle();
            w++;
        end while (acc_port != p && w < 10);
        chk(name, acc_port, p);
    endtask

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int c0, ta;
        int exp_seq [4];
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        for (int p = 0; p < 2; p++) begin
            t_addr[p]  = '0;
            t_wdata[p] = '0;
        end
        @(negedge clk);
        preload = 1'b0;
        do_reset();

        vecs[0] = '{0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 32'h20, 32'h1234,     1'b0, 32'h0};
        vecs[2] = '{0, 1'b0, 32'h20, 32'h0,        1'b0, 32'h1234};
        vecs[3] = '{0, 1'b0, 32'h13, 32'h0,        1'b1, 32'h0};
        vecs[4] = '{1, 1'b1, 32'h22, 32'hFFFF,     1'b1, 32'h0};
        vecs[5] = '{1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h1234};
        vecs[6] = '{0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[7] = '{1, 1'b0, 32'h40, 32'h0,        1'b0, 32'hA5A5A5A5};

        // Each vector: valid dropped right after acceptance, one response expected.
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            acc_port = -1;
            wait_accept(vecs[i].port, "vec_accept");
            req_valid = 2'b00;
            c0 = rsp_cnt;
            repeat (3) cycle();
            chk("vec_rsp_count", rsp_cnt - c0, 1);
            chk("vec_rdata", last_rdata, vecs[i].exp_rdata);
            chk("vec_err", last_err, vecs[i].exp_err);
        end

        // Contention from reset: core, dbg, core, dbg.
        do_reset();
        exp_seq = '{0, 1, 0, 1};
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            acc_port = -1;
            do begin
                cycle();
                w++;
            end while (acc_port < 0 && w < 5);
            chk("contention_grant", acc_port, exp_seq[k]);
        end
        req_valid = 2'b00;
        repeat (3) cycle();

        // Back-to-back: core accepted in the dbg response cycle.
        set_req(1, 1'b1, 32'h20, 32'h5);
        acc_port = -1;
        wait_accept(1, "b2b_dbg_accept");
        ta = acc_cyc;
        req_valid[1] = 1'b0;
        set_req(0, 1'b0, 32'h20, 32'h0);
        wait_accept(0, "b2b_core_accept");
        chk("b2b_gap", acc_cyc - ta, 2);
        req_valid = 2'b00;
        repeat (3) cycle();
        chk("b2b_rdata", last_rdata, 32'h5);

        // Reset during ACCESS drops the request; core wins the next contention.
        set_req(0, 1'b0, 32'h10, 32'h0);
        acc_port = -1;
        wait_accept(0, "rst_pre_accept");
        c0 = rsp_cnt;
        do_reset();
        repeat (4) cycle();
        chk("rst_no_rsp", rsp_cnt - c0, 0);
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h40, 32'h0);
        acc_port = -1;
        cycle();
        chk("rst_contention_core", acc_port, 0);
        req_valid = 2'b00;
        repeat (3) cycle();

        // Randomized traffic: payload held stable until accepted.
        acc_port = -1;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (acc_port == p) req_valid[p] = 1'b0;
                if (!req_valid[p] && $urandom_range(0, 2) != 0) begin
                    logic [AW-1:0] a;
                    a = AW'($urandom_range(0, 15)) << 2;
                    if ($urandom_range(0, 3) == 0) a = a + AW'($urandom_range(1, 3));
                    set_req(p, 1'($urandom_range(0, 1)), a, $urandom);
                end
            end
            cycle();
        end
        for (int p = 0; p < 2; p++) if (acc_port == p) req_valid[p] = 1'b0;
        c0 = 0;
        while (req_valid != 2'b00 && c0 < 10) begin
            cycle();
            for (int p = 0; p < 2; p++) if (acc_port == p) req_valid[p] = 1'b0;
            c0++;
        end
        chk("drain_timeout", req_valid, 0);
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
